// File: rtl/alu_share_if.sv
// Request, shared-ALU and response signals of the two-port ALU share arbiter.
// The arbiter connects to the slave modport; requesters, the ALU and the result consumer connect to master.
interface alu_share_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_data1;
    logic [DATA_WIDTH-1:0] req0_data2;
    logic [SEL_WIDTH-1:0]  req0_select;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_data1;
    logic [DATA_WIDTH-1:0] req1_data2;
    logic [SEL_WIDTH-1:0]  req1_select;

    logic [DATA_WIDTH-1:0] alu_data1;
    logic [DATA_WIDTH-1:0] alu_data2;
    logic [SEL_WIDTH-1:0]  alu_select;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;

    modport slave (
        input  req0_valid, req0_data1, req0_data2, req0_select,
        output req0_ready,
        input  req1_valid, req1_data1, req1_data2, req1_select,
        output req1_ready,
        output alu_data1, alu_data2, alu_select,
        input  alu_result,
        output resp_valid, resp_id, resp_result, resp_zero,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_data1, req0_data2, req0_select,
        input  req0_ready,
        output req1_valid, req1_data1, req1_data2, req1_select,
        input  req1_ready,
        input  alu_data1, alu_data2, alu_select,
        output alu_result,
        input  resp_valid, resp_id, resp_result, resp_zero,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: accept one op, hold operands for the settle window, capture result.
// Define ARB_ROUND_ROBIN_EN to alternate tie priority after each response; otherwise port 0 always wins ties.
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus
);
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_WIDTH-1:0] alu_data1_reg, alu_data2_reg, resp_result_reg;
    logic [SEL_WIDTH-1:0]  alu_select_reg;
    logic                  resp_valid_reg, resp_id_reg, resp_zero_reg;

    logic [1:0] req_valid;
    logic [1:0] grant;
    logic [1:0] ready;
    logic       prio;
    logic       accept;
    logic       consume;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // prio names the port that wins when both request together
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (prio == 1'(gi)));
            assign ready[gi] = rst_n & (state_reg == ST_IDLE) & grant[gi];
        end
    endgenerate

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign accept  = |ready;
    assign consume = (state_reg == ST_DONE) & resp_valid_reg & bus.resp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: if (cnt_reg == CNT_ONE) state_next = ST_DONE;
            ST_DONE:  if (consume) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            alu_data1_reg   <= '0;
            alu_data2_reg   <= '0;
            alu_select_reg  <= '0;
            resp_result_reg <= '0;
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= 1'b0;
            resp_zero_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        alu_data1_reg  <= grant[1] ? bus.req1_data1  : bus.req0_data1;
                        alu_data2_reg  <= grant[1] ? bus.req1_data2  : bus.req0_data2;
                        alu_select_reg <= grant[1] ? bus.req1_select : bus.req0_select;
                        resp_id_reg    <= grant[1];
                        cnt_reg        <= CNT_LOAD;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_reg == CNT_ONE) begin
                        resp_result_reg <= bus.alu_result;
                        resp_zero_reg   <= (bus.alu_result == '0);
                        resp_valid_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    // result stays visible after consumption; only the flags drop
                    if (consume) begin
                        resp_valid_reg <= 1'b0;
                        resp_zero_reg  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (consume) begin
            prio_reg <= ~resp_id_reg;
        end
    end

    assign prio = prio_reg;
`else
    assign prio = 1'b0;
`endif

    assign bus.alu_data1   = alu_data1_reg;
    assign bus.alu_data2   = alu_data2_reg;
    assign bus.alu_select  = alu_select_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_id     = resp_id_reg;
    assign bus.resp_result = resp_result_reg;
    assign bus.resp_zero   = resp_zero_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU (AND/OR/ADD/MOV).
module tb_alu_share_arbiter;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MOV = 3'd3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_share_if #(.DATA_WIDTH(8), .SEL_WIDTH(3)) bus ();

    alu_share_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_select)
            OP_AND:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
            OP_OR:   bus.alu_result = bus.alu_data1 | bus.alu_data2;
            OP_ADD:  bus.alu_result = bus.alu_data1 + bus.alu_data2;
            OP_MOV:  bus.alu_result = bus.alu_data1;
            default: bus.alu_result = 8'h00;
        endcase
    end

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_data1 = 0; bus.req0_data2 = 0; bus.req0_select = 0;
        bus.req1_valid = 0; bus.req1_data1 = 0; bus.req1_data2 = 0; bus.req1_select = 0;
        bus.resp_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        #2;
        rst_n = 0;
        bus.req0_valid = 1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00 || bus.alu_select !== 3'd0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h want 00 00 0", bus.alu_data1, bus.alu_data2, bus.alu_select); end
        n_checks++; if (bus.resp_result !== 8'h00 || bus.resp_id !== 1'b0 || bus.resp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %h %b %b want 00 0 0", bus.resp_result, bus.resp_id, bus.resp_zero); end
        bus.req0_valid = 0;
        rst_n = 1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_data1 = 8'h07; bus.req0_data2 = 8'h04; bus.req0_select = OP_AND;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready: got %b%b want 01", bus.req1_ready, bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_accept: ready %b valid %b want 0 0", bus.req0_ready, bus.resp_valid); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", bus.resp_valid); end
        n_checks++; if (bus.resp_result !== 8'h04 || bus.resp_id !== 1'b0 || bus.resp_zero !== 1'b0) begin n_fail++; $display("FAIL basic_resp: got %h id %b z %b want 04 id 0 z 0", bus.resp_result, bus.resp_id, bus.resp_zero); end
        consume();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.alu_data1 !== 8'h07 || bus.alu_select !== OP_AND) begin n_fail++; $display("FAIL basic_alu_hold: got %h %h want 07 0", bus.alu_data1, bus.alu_select); end
        $display("basic: AND 07&04 -> %h id %b", bus.resp_result, bus.resp_id);
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        bus.req0_valid = 1; bus.req0_data1 = 8'h0F; bus.req0_data2 = 8'hF0; bus.req0_select = OP_AND;
        bus.req1_valid = 1; bus.req1_data1 = 8'h0C; bus.req1_data2 = 8'h08; bus.req1_select = OP_AND;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL prio_grant: got r1r0 %b%b want 01", bus.req1_ready, bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        wait_resp(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_timeout0: got no response want response"); end
        n_checks++; if (bus.resp_result !== 8'h00 || bus.resp_zero !== 1'b1 || bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL prio_resp0: got %h z %b id %b want 00 z 1 id 0", bus.resp_result, bus.resp_zero, bus.resp_id); end
        consume();
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready1: got %b want 1", bus.req1_ready); end
        wait_resp(ok);
        bus.req1_valid = 0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_timeout1: got no response want response"); end
        n_checks++; if (bus.resp_result !== 8'h08 || bus.resp_zero !== 1'b0 || bus.resp_id !== 1'b1) begin n_fail++; $display("FAIL prio_resp1: got %h z %b id %b want 08 z 0 id 1", bus.resp_result, bus.resp_zero, bus.resp_id); end
        consume();
        $display("priority: port0 then port1 -> %h id %b", bus.resp_result, bus.resp_id);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] exp_ids;
        logic [7:0] exp_res;
`ifdef ARB_ROUND_ROBIN_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        do_reset();
        bus.req0_valid = 1; bus.req0_data1 = 8'h01; bus.req0_data2 = 8'h02; bus.req0_select = OP_OR;
        bus.req1_valid = 1; bus.req1_data1 = 8'h01; bus.req1_data2 = 8'h01; bus.req1_select = OP_ADD;
        for (int k = 0; k < 4; k++) begin
            wait_resp(ok);
            exp_res = exp_ids[k] ? 8'h02 : 8'h03;
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout[%0d]: got no response want response", k); end
            n_checks++; if (bus.resp_id !== exp_ids[k] || bus.resp_result !== exp_res) begin n_fail++; $display("FAIL b2b_id[%0d]: got id %b res %h want id %b res %h", k, bus.resp_id, bus.resp_result, exp_ids[k], exp_res); end
            $display("back_to_back op %0d: id %b result %h", k, bus.resp_id, bus.resp_result);
            consume();
        end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        bus.req0_valid = 1; bus.req0_data1 = 8'h5A; bus.req0_data2 = 8'h00; bus.req0_select = OP_MOV;
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_data1 = 8'hFF; bus.req1_data2 = 8'h33; bus.req1_select = OP_AND;
        wait_resp(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no response want response"); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== 8'h5A || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v %b res %h r1 %b want v 1 res 5a r1 0", i, bus.resp_valid, bus.resp_result, bus.req1_ready); end
            @(negedge clk);
        end
        consume();
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got r1 %b v %b want r1 1 v 0", bus.req1_ready, bus.resp_valid); end
        @(negedge clk);
        bus.req1_valid = 0;
        wait_resp(ok);
        n_checks++; if (!ok || bus.resp_id !== 1'b1 || bus.resp_result !== 8'h33) begin n_fail++; $display("FAIL bp_resp1: got ok %b id %b res %h want ok 1 id 1 res 33", ok, bus.resp_id, bus.resp_result); end
        $display("backpressure: held 10 cycles, then port1 -> %h", bus.resp_result);
        consume();
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        do_reset();
        bus.req0_valid = 1; bus.req0_data1 = 8'h3C; bus.req0_data2 = 8'h0F; bus.req0_select = OP_OR;
        @(negedge clk);
        n_checks++; if (bus.alu_data1 !== 8'h3C || bus.alu_select !== OP_OR) begin n_fail++; $display("FAIL mid_latched: got %h %h want 3c 1", bus.alu_data1, bus.alu_select); end
        rst_n = 0;
        #1;
        n_checks++; if (bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00 || bus.alu_select !== 3'd0) begin n_fail++; $display("FAIL mid_alu_clear: got %h %h %h want 00 00 0", bus.alu_data1, bus.alu_data2, bus.alu_select); end
        n_checks++; if (bus.req0_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_outputs: got r0 %b v %b want 0 0", bus.req0_ready, bus.resp_valid); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp: got %b want 0", bus.resp_valid); end
        rst_n = 1;
        bus.req0_data1 = 8'h12; bus.req0_data2 = 8'h34; bus.req0_select = OP_ADD;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        wait_resp(ok);
        n_checks++; if (!ok || bus.resp_result !== 8'h46 || bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL mid_new_op: got ok %b res %h id %b want ok 1 res 46 id 0", ok, bus.resp_result, bus.resp_id); end
        $display("reset_mid_issue: recovered op -> %h", bus.resp_result);
        consume();
    endtask

    task automatic test_operand_change();
        bit ok;
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_data1 = 8'h10; bus.req0_data2 = 8'h05; bus.req0_select = OP_ADD;
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req0_data1 = 8'hFF;
        #1;
        n_checks++; if (bus.alu_data1 !== 8'h10) begin n_fail++; $display("FAIL opchg_latched: got %h want 10", bus.alu_data1); end
        wait_resp(ok);
        n_checks++; if (!ok || bus.resp_result !== 8'h15) begin n_fail++; $display("FAIL opchg_result: got ok %b res %h want ok 1 res 15", ok, bus.resp_result); end
        $display("operand_change: ADD 10+05 with late DATA1=ff -> %h", bus.resp_result);
        consume();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_priority();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_issue();
        test_operand_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
